// File: rtl/cla_sub_12bit_pipe.sv
// Two-stage pipelined 12-bit carry-lookahead subtractor: diff = {borrow_out, a - b - b_in}.
// Stage 1 registers bit and group propagate/generate terms; stage 2 resolves carries and forms the result.
module cla_sub_12bit_pipe #(
  parameter int DATA_WIDTH  = 12,
  parameter int GROUP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   diff,
  output logic                  ovf
);

  // Group generate/propagate: returns {G, P} for one 4-bit group.
  function automatic logic [1:0] grp_gp(input logic [GROUP_WIDTH-1:0] p,
                                        input logic [GROUP_WIDTH-1:0] g);
    logic gen;
    gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gen, &p};
  endfunction

  // Carries into each bit of a group, fully expanded from the group carry-in.
  function automatic logic [GROUP_WIDTH-1:0] grp_carry(input logic [GROUP_WIDTH-1:0] p,
                                                       input logic [GROUP_WIDTH-1:0] g,
                                                       input logic cin);
    logic [GROUP_WIDTH-1:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  logic                  s1_load, s2_load;
  logic [DATA_WIDTH-1:0] nb, p_in, g_in;
  logic [2:0]            gg_in, gp_in;
  logic                  c4, c8, c12;
  logic [DATA_WIDTH-1:0] c_bits, sum;

  logic                  vld_p1_q, vld_p1_d;
  logic [DATA_WIDTH-1:0] p_p1_q, p_p1_d, g_p1_q, g_p1_d;
  logic [2:0]            gg_p1_q, gg_p1_d, gp_p1_q, gp_p1_d;
  logic                  c0_p1_q, c0_p1_d;
  logic                  amsb_p1_q, amsb_p1_d, bmsb_p1_q, bmsb_p1_d;

  logic                  vld_p2_q, vld_p2_d;
  logic [DATA_WIDTH:0]   diff_p2_q, diff_p2_d;
  logic                  ovf_p2_q, ovf_p2_d;

  always_comb begin
    s2_load  = ~vld_p2_q | out_ready;
    s1_load  = ~vld_p1_q | s2_load;
    in_ready = s1_load;

    // Stage 0 -> 1: subtraction as a + ~b + ~b_in.
    nb   = ~b;
    p_in = a ^ nb;
    g_in = a & nb;
    for (int k = 0; k < 3; k++) begin
      {gg_in[k], gp_in[k]} = grp_gp(p_in[k*GROUP_WIDTH +: GROUP_WIDTH],
                                    g_in[k*GROUP_WIDTH +: GROUP_WIDTH]);
    end

    vld_p1_d  = vld_p1_q;
    p_p1_d    = p_p1_q;
    g_p1_d    = g_p1_q;
    gg_p1_d   = gg_p1_q;
    gp_p1_d   = gp_p1_q;
    c0_p1_d   = c0_p1_q;
    amsb_p1_d = amsb_p1_q;
    bmsb_p1_d = bmsb_p1_q;
    if (s1_load) begin
      vld_p1_d  = in_valid;
      p_p1_d    = p_in;
      g_p1_d    = g_in;
      gg_p1_d   = gg_in;
      gp_p1_d   = gp_in;
      c0_p1_d   = ~b_in;
      amsb_p1_d = a[DATA_WIDTH-1];
      bmsb_p1_d = b[DATA_WIDTH-1];
    end

    // Stage 1 -> 2: group carries, then per-bit lookahead inside each group.
    c4  = gg_p1_q[0] | (gp_p1_q[0] & c0_p1_q);
    c8  = gg_p1_q[1] | (gp_p1_q[1] & c4);
    c12 = gg_p1_q[2] | (gp_p1_q[2] & c8);
    c_bits = {grp_carry(p_p1_q[11:8], g_p1_q[11:8], c8),
              grp_carry(p_p1_q[7:4],  g_p1_q[7:4],  c4),
              grp_carry(p_p1_q[3:0],  g_p1_q[3:0],  c0_p1_q)};
    sum = p_p1_q ^ c_bits;

    vld_p2_d  = vld_p2_q;
    diff_p2_d = diff_p2_q;
    ovf_p2_d  = ovf_p2_q;
    if (s2_load) begin
      vld_p2_d  = vld_p1_q;
      diff_p2_d = {~c12, sum};
      ovf_p2_d  = (amsb_p1_q != bmsb_p1_q) && (sum[DATA_WIDTH-1] != amsb_p1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_p1_q  <= 1'b0;
      p_p1_q    <= '0;
      g_p1_q    <= '0;
      gg_p1_q   <= '0;
      gp_p1_q   <= '0;
      c0_p1_q   <= 1'b0;
      amsb_p1_q <= 1'b0;
      bmsb_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      diff_p2_q <= '0;
      ovf_p2_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      p_p1_q    <= p_p1_d;
      g_p1_q    <= g_p1_d;
      gg_p1_q   <= gg_p1_d;
      gp_p1_q   <= gp_p1_d;
      c0_p1_q   <= c0_p1_d;
      amsb_p1_q <= amsb_p1_d;
      bmsb_p1_q <= bmsb_p1_d;
      vld_p2_q  <= vld_p2_d;
      diff_p2_q <= diff_p2_d;
      ovf_p2_q  <= ovf_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign diff      = diff_p2_q;
  assign ovf       = ovf_p2_q;

endmodule

// File: tb/tb_cla_sub_12bit_pipe.sv
// Scoreboard bench for cla_sub_12bit_pipe: expected results queued at acceptance,
// popped and compared by an independent output monitor.
module tb_cla_sub_12bit_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, b_in, out_valid, out_ready, ovf;
  logic [11:0] a, b;
  logic [12:0] diff;

  logic [13:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          acc_cnt  = 0;
  int          ov_cnt   = 0;
  bit          rand_ready = 1'b0;

  cla_sub_12bit_pipe #(.DATA_WIDTH(12), .GROUP_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction; returns {ovf, borrow, diff[11:0]}.
  function automatic logic [13:0] model(input logic [11:0] av, input logic [11:0] bv,
                                        input logic bi);
    int   r;
    logic [12:0] d;
    logic        o;
    r = int'(av) - int'(bv) - int'(bi);
    d = 13'(r);
    o = (av[11] != bv[11]) && (d[11] != av[11]);
    return {o, d};
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] av, input logic [11:0] bv, input logic bi);
    int t;
    t = 0;
    in_valid = 1'b1; a = av; b = bv; b_in = bi;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 1000) begin
        n_checks++;
        $display("FAIL send_timeout in_ready stuck at %0b, required 1", in_ready);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) begin
      n_checks++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
    end
  endtask

  // Output monitor: records acceptances, compares presented results, checks stall stability.
  initial begin
    logic        prev_stall;
    logic [13:0] held;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, b_in));
          acc_cnt++;
        end
        if (prev_stall) begin
          check("stall_valid_held", {13'b0, out_valid}, 14'd1);
          check("stall_data_held", {ovf, diff}, held);
        end
        if (out_valid) begin
          ov_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result got=%h required no output", {ovf, diff});
          end else begin
            check("result", {ovf, diff}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        held       = {ovf, diff};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {13'b0, out_valid}, 14'd0);
    check("reset_data", {ovf, diff}, 14'd0);
    check("reset_in_ready", {13'b0, in_ready}, 14'd1);
    tick();

    // Latency of the first transaction.
    send(12'h005, 12'h003, 1'b0);
    @(negedge clk);
    check("latency_cycle1_valid", {13'b0, out_valid}, 14'd0);
    tick();
    @(negedge clk);
    check("latency_cycle2_valid", {13'b0, out_valid}, 14'd1);
    check("first_diff", {ovf, diff}, {1'b0, 13'h0002});
    tick();

    // Borrow and overflow corners.
    send(12'h000, 12'h001, 1'b0);
    send(12'h800, 12'h001, 1'b0);
    send(12'h7FF, 12'hFFF, 1'b1);
    send(12'h800, 12'h000, 1'b1);
    send(12'hFFF, 12'h000, 1'b0);
    drain();

    // Back-to-back stream at full throughput.
    c0 = ov_cnt;
    for (int i = 0; i < 8; i++) send(12'($urandom), 12'($urandom), 1'($urandom));
    tick();
    tick();
    check("stream_valid_cycles", 14'(ov_cnt - c0), 14'd8);
    drain();

    // Stall: downstream blocked for four edges.
    out_ready = 1'b0;
    c0 = acc_cnt;
    send(12'h123, 12'h045, 1'b0);
    send(12'h010, 12'h020, 1'b1);
    in_valid = 1'b1; a = 12'hABC; b = 12'h0FF; b_in = 1'b0;
    @(negedge clk);
    check("stall_in_ready_low", {13'b0, in_ready}, 14'd0);
    check("stall_accept_count", 14'(acc_cnt - c0), 14'd2);
    tick();
    @(negedge clk);
    tick();
    out_ready = 1'b1;
    send(12'hABC, 12'h0FF, 1'b0);
    send(12'h7FF, 12'h800, 1'b0);
    drain();
    check("stall_accept_total", 14'(acc_cnt - c0), 14'd4);

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    send(12'h111, 12'h222, 1'b0);
    send(12'h333, 12'h444, 1'b1);
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    rst_n = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", {13'b0, out_valid}, 14'd0);
    check("midreset_data", {ovf, diff}, 14'd0);
    check("midreset_in_ready", {13'b0, in_ready}, 14'd1);
    tick();
    send(12'h050, 12'h00F, 1'b1);
    @(negedge clk);
    check("postreset_cycle1_valid", {13'b0, out_valid}, 14'd0);
    tick();
    @(negedge clk);
    check("postreset_cycle2_valid", {13'b0, out_valid}, 14'd1);
    check("postreset_diff", {ovf, diff}, {1'b0, 13'h0040});
    tick();
    drain();

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 0) tick();
      send(12'($urandom), 12'($urandom), 1'($urandom));
    end
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
